// File: rtl/frame_sched_if.sv
// frame_sched_if: signal bundle between the display/button front end and frame_sched.
//   master : drives vsync, button_raw, pause; observes the sequencer outputs
//   slave  : frame_sched side
//   vsync, button_raw, pause      : input levels to the sequencer
//   new_frame, button_pulse       : single-cycle strobes
//   render_hold, overrun, busy    : status levels
//   frame_count[15:0]             : wrapping count of new_frame strobes
interface frame_sched_if;
   logic        vsync;
   logic        button_raw;
   logic        pause;
   logic        new_frame;
   logic        button_pulse;
   logic        render_hold;
   logic [15:0] frame_count;
   logic        overrun;
   logic        busy;

   modport master (
      output vsync, button_raw, pause,
      input  new_frame, button_pulse, render_hold, frame_count, overrun, busy
   );

   modport slave (
      input  vsync, button_raw, pause,
      output new_frame, button_pulse, render_hold, frame_count, overrun, busy
   );
endinterface

// File: rtl/frame_sched.sv
// frame_sched: turns the vsync level into a paced one-cycle new_frame strobe,
// holds the renderer off game state while it updates, and debounces the push
// button into a one-cycle press strobe.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : frame_sched_if.slave (vsync, button_raw, pause in;
//          new_frame, button_pulse, render_hold, frame_count, overrun, busy out)
//
// state  | meaning
// IDLE   | waiting for a vsync rise; divides qualifying rises by FRAME_DIV
// FRAME  | one cycle: new_frame strobe, frame_count bumped, hold asserted
// SETTLE | hold asserted while the game's update pipeline finishes
// DONE   | hold released; wait for vsync low so one long vsync fires once
module frame_sched #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FRAME_DIV       = 1,
   parameter int SETTLE_CYCLES   = 4
) (
   input  logic          clk,
   input  logic          rst,
   frame_sched_if.slave  bus
);

   localparam int         DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] DIV_LAST    = 4'(FRAME_DIV - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FRAME, SETTLE, DONE} state_t;

   state_t      state;
   logic        vsync_q;
   logic        vs_rise;
   logic [3:0]  div;
   logic [7:0]  settle_cnt;
   logic        new_frame_r;
   logic        render_hold_r;
   logic [15:0] frame_count_r;
   logic        overrun_r;
   logic        busy_r;

   logic            btn_s1;
   logic            btn_s2;
   logic [DB_W-1:0] db_cnt;
   logic            db_level;
   logic            db_level_q;
   logic            button_pulse_r;

   // Rise is registered, so the FSM acts one cycle after vsync is first seen high.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q <= 1'b0;
         vs_rise <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         vs_rise <= bus.vsync & ~vsync_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         div           <= 4'd0;
         settle_cnt    <= 8'd0;
         new_frame_r   <= 1'b0;
         render_hold_r <= 1'b0;
         frame_count_r <= 16'd0;
         overrun_r     <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         new_frame_r <= 1'b0;
         case (state)
            IDLE: begin
               if (vs_rise && !bus.pause) begin
                  if (div == DIV_LAST) begin
                     div           <= 4'd0;
                     state         <= FRAME;
                     new_frame_r   <= 1'b1;
                     render_hold_r <= 1'b1;
                     busy_r        <= 1'b1;
                     frame_count_r <= frame_count_r + 16'd1;
                  end else begin
                     div <= div + 4'd1;
                  end
               end
            end
            FRAME: begin
               settle_cnt <= SETTLE_LOAD;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (!bus.vsync) overrun_r <= 1'b1;
               settle_cnt <= settle_cnt - 8'd1;
               // Leaving as the count reaches zero gives FRAME + (SETTLE_CYCLES-1) hold cycles.
               if (settle_cnt == 8'd1) begin
                  state         <= DONE;
                  render_hold_r <= 1'b0;
               end
            end
            DONE: begin
               if (!bus.vsync) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1         <= 1'b0;
         btn_s2         <= 1'b0;
         db_cnt         <= '0;
         db_level       <= 1'b0;
         db_level_q     <= 1'b0;
         button_pulse_r <= 1'b0;
      end else begin
         btn_s1         <= bus.button_raw;
         btn_s2         <= btn_s1;
         db_level_q     <= db_level;
         button_pulse_r <= db_level & ~db_level_q;
         if (btn_s2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= ~db_level;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign bus.new_frame    = new_frame_r;
   assign bus.render_hold  = render_hold_r;
   assign bus.frame_count  = frame_count_r;
   assign bus.overrun      = overrun_r;
   assign bus.busy         = busy_r;
   assign bus.button_pulse = button_pulse_r;

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: stimulus tables for vsync/pause/rst/button are built up
// front (directed scenarios followed by a random section), a frame-level
// reference model derives the expected outputs after every clock edge, and
// the run compares the DUT against them plus a set of directed checkpoints.
module tb_frame_sched;
   localparam int DEB = 4;
   localparam int FD  = 2;
   localparam int SC  = 3;
   localparam int N   = 4000;

   logic clk = 1'b0;
   logic rst;

   frame_sched_if bus();

   frame_sched #(
      .DEBOUNCE_CYCLES(DEB),
      .FRAME_DIV      (FD),
      .SETTLE_CYCLES  (SC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Index c: value driven before clock edge c / expected value just after it.
   bit vs_a[N], pz_a[N], rs_a[N], bt_a[N];
   bit e_nf[N], e_rh[N], e_bz[N], e_ov[N], e_bp[N];
   int e_fc[N];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk_val(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
      end
   endtask

   task automatic vs_pulse(input int s, input int len);
      for (int k = s; k < s + len && k < N; k++) vs_a[k] = 1'b1;
   endtask

   task automatic fill_pause(input int s, input int e);
      for (int k = s; k < e && k < N; k++) pz_a[k] = 1'b1;
   endtask

   task automatic fill_rst(input int s, input int e);
      for (int k = s; k < e && k < N; k++) rs_a[k] = 1'b1;
   endtask

   task automatic fill_btn(input int s, input int e, input bit v);
      for (int k = s; k < e && k < N; k++) bt_a[k] = v;
   endtask

   task automatic build_stim();
      int t, len, gap, hold;
      bit p;
      fill_rst(0, 3);
      // pacing: 6 pulses, frames on 2, 4, 6
      for (int i = 0; i < 6; i++) vs_pulse(10 + 100 * i, 20);
      // pause across pulses 1-3
      fill_rst(650, 652);
      fill_pause(690, 1000);
      for (int i = 0; i < 5; i++) vs_pulse(700 + 100 * i, 20);
      // overrun on a 2-cycle vsync
      fill_rst(1190, 1192);
      vs_pulse(1200, 20);
      vs_pulse(1300, 2);
      vs_pulse(1400, 20);
      vs_pulse(1500, 20);
      // bouncing button then stable hold, then release
      for (int k = 1600; k < 1620; k++) bt_a[k] = (((k - 1600) / 2) % 2) == 0;
      fill_btn(1620, 1700, 1'b1);
      // button pulse coinciding with new_frame
      vs_pulse(1800, 20);
      vs_pulse(1900, 20);
      fill_btn(1895, 1950, 1'b1);
      // reset one cycle into SETTLE
      fill_rst(1990, 1992);
      vs_pulse(2000, 20);
      vs_pulse(2100, 3);
      fill_rst(2103, 2104);
      vs_pulse(2200, 20);
      vs_pulse(2300, 20);
      // random section
      t = 2400;
      while (t < 3850) begin
         len = $urandom_range(1, 25);
         gap = $urandom_range(1, 30);
         p   = ($urandom_range(0, 3) == 0);
         vs_pulse(t, len);
         if (p) fill_pause(t, t + len + gap);
         if ($urandom_range(0, 15) == 0) fill_rst(t + len + gap - 1, t + len + gap);
         t += len + gap;
      end
      t = 2400;
      while (t < 3950) begin
         hold = $urandom_range(1, 10);
         fill_btn(t, t + hold, 1'($urandom_range(0, 1)));
         t += hold;
      end
   endtask

   // Frame-level model: each qualifying rise opens a sequence whose windows
   // (strobe, hold, busy, overrun) are written straight into the tables.
   task automatic build_model();
      int div = 0, fc = 0, idle_at = 0, rise_at = -10, ov_at = -1;
      int run = 0, rst_last = -10, x;
      bit ov = 0, prev = 0, lvl = 0, flip1 = 0, samp;
      for (int c = 0; c < N; c++) begin
         if (rs_a[c]) begin
            div = 0; fc = 0; ov = 0; ov_at = -1; idle_at = c; rise_at = -10; prev = 0;
            lvl = 0; run = 0; flip1 = 0; rst_last = c;
            for (int k = c; k < N; k++) begin
               e_nf[k] = 0; e_rh[k] = 0; e_bz[k] = 0;
            end
            e_fc[c] = 0; e_ov[c] = 0; e_bp[c] = 0;
            continue;
         end
         if (rise_at == c - 1 && c - 1 >= idle_at && !pz_a[c]) begin
            if (div == FD - 1) begin
               div = 0;
               fc  = (fc + 1) % 65536;
               e_nf[c] = 1;
               for (int k = c; k < c + SC && k < N; k++) e_rh[k] = 1;
               x = c + SC + 1;
               while (x < N && vs_a[x]) x++;
               for (int k = c; k < x && k < N; k++) e_bz[k] = 1;
               idle_at = x;
               for (int e = c + 2; e <= c + SC && e < N; e++) begin
                  if (!vs_a[e]) begin
                     ov_at = e;
                     break;
                  end
               end
            end else begin
               div++;
            end
         end
         if (vs_a[c] && !prev) rise_at = c;
         prev = vs_a[c];
         if (c == ov_at) ov = 1;
         e_fc[c] = fc;
         e_ov[c] = ov;
         // button: DEB consecutive differing synced samples flip the level
         e_bp[c] = flip1;
         flip1 = 0;
         samp = (c >= 2 && c - 2 > rst_last) ? bt_a[c - 2] : 1'b0;
         if (samp != lvl) begin
            run++;
            if (run == DEB) begin
               lvl   = !lvl;
               run   = 0;
               flip1 = lvl;
            end
         end else begin
            run = 0;
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.vsync      = 1'b0;
      bus.pause      = 1'b0;
      bus.button_raw = 1'b0;
      build_stim();
      build_model();
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         rst            = rs_a[c];
         bus.vsync      = vs_a[c];
         bus.pause      = pz_a[c];
         bus.button_raw = bt_a[c];
         @(posedge clk);
         #1;
         cyc = c;
         chk_val("new_frame",    int'(bus.new_frame),    int'(e_nf[c]));
         chk_val("render_hold",  int'(bus.render_hold),  int'(e_rh[c]));
         chk_val("busy",         int'(bus.busy),         int'(e_bz[c]));
         chk_val("overrun",      int'(bus.overrun),      int'(e_ov[c]));
         chk_val("button_pulse", int'(bus.button_pulse), int'(e_bp[c]));
         chk_val("frame_count",  int'(bus.frame_count),  e_fc[c]);
         case (c)
            2: begin
               chk_val("rst_busy", int'(bus.busy), 0);
               chk_val("rst_fc",   int'(bus.frame_count), 0);
               chk_val("rst_hold", int'(bus.render_hold), 0);
            end
            11:   chk_val("t1_first_rise_no_frame", int'(bus.new_frame), 0);
            111:  chk_val("t1_frame_latency", int'(bus.new_frame), 1);
            113:  chk_val("t1_hold_last", int'(bus.render_hold), 1);
            114:  chk_val("t1_hold_end", int'(bus.render_hold), 0);
            600:  chk_val("t1_frame_count", int'(bus.frame_count), 3);
            901:  chk_val("t2_paused", int'(bus.new_frame), 0);
            1001: chk_val("t2_div_first", int'(bus.new_frame), 0);
            1101: chk_val("t2_frame", int'(bus.new_frame), 1);
            1180: chk_val("t2_frame_count", int'(bus.frame_count), 1);
            1301: chk_val("t3_frame", int'(bus.new_frame), 1);
            1302: chk_val("t3_overrun_pre", int'(bus.overrun), 0);
            1303: begin
               chk_val("t3_overrun_set", int'(bus.overrun), 1);
               chk_val("t3_hold", int'(bus.render_hold), 1);
            end
            1304: chk_val("t3_hold_end", int'(bus.render_hold), 0);
            1590: chk_val("t3_overrun_sticky", int'(bus.overrun), 1);
            1625: chk_val("t4_pulse_early", int'(bus.button_pulse), 0);
            1626: chk_val("t4_pulse", int'(bus.button_pulse), 1);
            1627: chk_val("t4_pulse_single", int'(bus.button_pulse), 0);
            1706: chk_val("t4_release", int'(bus.button_pulse), 0);
            1901: begin
               chk_val("t5_frame", int'(bus.new_frame), 1);
               chk_val("t5_pulse", int'(bus.button_pulse), 1);
            end
            2102: chk_val("t6_hold_pre", int'(bus.render_hold), 1);
            2103: begin
               chk_val("t6_rst_hold", int'(bus.render_hold), 0);
               chk_val("t6_rst_busy", int'(bus.busy), 0);
               chk_val("t6_rst_fc",   int'(bus.frame_count), 0);
            end
            2201: chk_val("t6_div_restart", int'(bus.new_frame), 0);
            2301: chk_val("t6_frame", int'(bus.new_frame), 1);
            default: ;
         endcase
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
